servant_wb_arbiter: RTL and testbench
=====================================

Name: servant_wb_arbiter

Overview:
- Sequential Wishbone-classic arbiter that shares the servant RAM/peripheral slave port among three masters:
  - serv data bus (m0)
  - serv instruction bus (m1)
  - external debug/firmware-loader master (m2)
- Grants are registered and held until the slave acks or the transaction times out.
- Priority is round-robin.
- It drives the single slave port that feeds the servant memory mux.

Parameters:
- TIMEOUT, 255, number of granted cycles without slave ack before a forced error ack. 0 disables the timeout.
- TW, 8, width of the timeout counter. Must satisfy 2^TW > TIMEOUT.

Ports:
- wb_clk  in  1  clock
- wb_rst  in  1  synchronous active-high reset
- i_m0_adr, i_m1_adr, i_m2_adr  in  32  master address
- i_m0_dat, i_m1_dat, i_m2_dat  in  32  master write data
- i_m0_sel, i_m1_sel, i_m2_sel  in  4  byte selects
- i_m0_we, i_m1_we, i_m2_we  in  1  write enable
- i_m0_cyc, i_m1_cyc, i_m2_cyc  in  1  request/cycle valid
- o_m0_rdt, o_m1_rdt, o_m2_rdt  out  32  read data
- o_m0_ack, o_m1_ack, o_m2_ack  out  1  acknowledge
- o_s_adr  out  32  slave address
- o_s_dat  out  32  slave write data
- o_s_sel  out  4  slave byte selects
- o_s_we  out  1  slave write enable
- o_s_cyc  out  1  slave cycle
- i_s_rdt  in  32  slave read data
- i_s_ack  in  1  slave ack
- o_err  out  1  one-cycle pulse on timeout
- o_err_master  out  2  index of the master that timed out (held until the next timeout)

Behaviour:
- Reset values:
  - state=IDLE, grant=none, last-served=2 (so m0 is first priority).
  - o_s_cyc=0, all o_mX_ack=0, o_err=0, o_err_master=0, timeout counter=0.
- Reset mid-transaction:
  - Grant is dropped at that edge and no ack is issued.
  - The slave sees o_s_cyc=0 from the next cycle.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If any i_mX_cyc is set, select the winner round-robin: the first requester in order last+1, last+2, last (mod 3).
  - Register the grant and go to GRANT.
  - No requesters: stay in IDLE.
- GRANT:
  - o_s_cyc=1.
  - o_s_adr, o_s_dat, o_s_sel and o_s_we are muxed combinationally from the granted master.
  - o_mX_rdt = i_s_rdt for the granted master; non-granted masters see rdt=0 and ack=0.
  - o_mX_ack = i_s_ack (combinational, same cycle) for the granted master only.
  - On i_s_ack: set last-served = the granted index, clear the counter, go to RELEASE.
- Slave-ack latency: request sampled at edge t ⇒ o_s_cyc=1 from cycle t+1. A zero-wait slave acks in cycle t+1 ⇒ master ack in t+1.
- Timeout (TIMEOUT>0):
  - The counter increments each GRANT cycle without ack.
  - When the counter == TIMEOUT-1 and there is no ack, assert the granted master's ack with rdt=0 for that cycle.
  - Also pulse o_err, latch o_err_master, update last-served, and go to RELEASE.
  - o_s_cyc stays 1 in that cycle and drops in RELEASE.
- Simultaneous i_s_ack and timeout in the same cycle: a normal ack (slave rdt passed through), no o_err.
- RELEASE:
  - Exactly one cycle with o_s_cyc=0 and no acks, so the served master can drop cyc.
  - Then go to IDLE.
  - Requests are not sampled in RELEASE.
- A master deasserting cyc while granted is illegal. The arbiter keeps the grant until ack or timeout.
- Throughput: 3 cycles per transaction with a zero-wait slave (IDLE, GRANT, RELEASE).
- Spurious i_s_ack in IDLE/RELEASE is ignored.

Test Plan:
- **Single requester:** m1 cyc, adr=0x100, slave acks 1 cycle after o_s_cyc ⇒ o_s_adr=0x100; o_m1_ack for 1 cycle with rdt=0xDEADBEEF; o_s_cyc=0 in the next cycle.
- **Round-robin:** all three hold cyc continuously with a zero-wait slave ⇒ grant order m0, m1, m2, m0. Each grant is separated by a RELEASE cycle, and a new grant starts every 3 cycles.
- **Write passthrough:** m2 writes adr=0x2000, dat=0x12345678, sel=0x3, we=1 ⇒ slave sees exactly those values while o_s_cyc=1; m0/m1 acks stay 0.
- **Timeout:** TIMEOUT=4, m0 requests, slave never acks ⇒ o_m0_ack and o_err pulse in the 4th GRANT cycle, rdt=0, o_err_master=0. Next, m1 is granted after RELEASE.
- **Ack/timeout tie:** slave acks in exactly the 4th cycle with TIMEOUT=4 ⇒ o_err stays 0 and the master receives the slave rdt.
- **Reset mid-grant:** assert wb_rst while m1 is granted ⇒ o_s_cyc=0 and no ack after the edge. After reset is released with all requesting, m0 is granted first.

Source files
------------

// File: rtl/servant_wb_arbiter.sv
// Round-robin Wishbone-classic arbiter: three masters (serv dbus, serv ibus,
// debug/loader) share one slave port. A grant is held until the slave acks or
// the optional timeout forces an error ack. Each transaction is followed by one
// RELEASE cycle, so a served master has time to drop cyc before re-arbitration.
module servant_wb_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [31:0] i_m0_adr,
    input  logic [31:0] i_m0_dat,
    input  logic [3:0]  i_m0_sel,
    input  logic        i_m0_we,
    input  logic        i_m0_cyc,
    output logic [31:0] o_m0_rdt,
    output logic        o_m0_ack,
    input  logic [31:0] i_m1_adr,
    input  logic [31:0] i_m1_dat,
    input  logic [3:0]  i_m1_sel,
    input  logic        i_m1_we,
    input  logic        i_m1_cyc,
    output logic [31:0] o_m1_rdt,
    output logic        o_m1_ack,
    input  logic [31:0] i_m2_adr,
    input  logic [31:0] i_m2_dat,
    input  logic [3:0]  i_m2_sel,
    input  logic        i_m2_we,
    input  logic        i_m2_cyc,
    output logic [31:0] o_m2_rdt,
    output logic        o_m2_ack,
    output logic [31:0] o_s_adr,
    output logic [31:0] o_s_dat,
    output logic [3:0]  o_s_sel,
    output logic        o_s_we,
    output logic        o_s_cyc,
    input  logic [31:0] i_s_rdt,
    input  logic        i_s_ack,
    output logic        o_err,
    output logic [1:0]  o_err_master
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    // Last counter value before the forced ack; unused when TIMEOUT is 0.
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    state_t      state_reg, state_next;
    logic [1:0]  grant_reg, grant_next;
    logic [1:0]  last_reg, last_next;
    logic [TW-1:0] cnt_reg, cnt_next;
    logic [1:0]  err_master_reg, err_master_next;

    // Master buses gathered into arrays so muxing and fan-out are indexed.
    logic [31:0] m_adr [3];
    logic [31:0] m_dat [3];
    logic [3:0]  m_sel [3];
    logic [2:0]  m_we;
    logic [2:0]  m_cyc;
    logic [31:0] m_rdt [3];
    logic [2:0]  m_ack;

    assign m_adr[0] = i_m0_adr;
    assign m_adr[1] = i_m1_adr;
    assign m_adr[2] = i_m2_adr;
    assign m_dat[0] = i_m0_dat;
    assign m_dat[1] = i_m1_dat;
    assign m_dat[2] = i_m2_dat;
    assign m_sel[0] = i_m0_sel;
    assign m_sel[1] = i_m1_sel;
    assign m_sel[2] = i_m2_sel;
    assign m_we     = {i_m2_we, i_m1_we, i_m0_we};
    assign m_cyc    = {i_m2_cyc, i_m1_cyc, i_m0_cyc};

    logic granted;
    logic timeout_hit;

    assign granted     = (state_reg == GRANT);
    // A real ack in the same cycle wins over the timeout.
    assign timeout_hit = (TIMEOUT > 0) && granted && !i_s_ack && (cnt_reg == TO_LAST);

    assign o_s_cyc = granted;
    assign o_s_adr = granted ? m_adr[grant_reg] : '0;
    assign o_s_dat = granted ? m_dat[grant_reg] : '0;
    assign o_s_sel = granted ? m_sel[grant_reg] : '0;
    assign o_s_we  = granted ? m_we[grant_reg]  : 1'b0;

    assign o_err        = timeout_hit;
    // Show the offending master already in the pulse cycle, then hold it.
    assign o_err_master = timeout_hit ? grant_reg : err_master_reg;

    // Per-master return path: only the granted master sees ack/rdt; a forced
    // (timeout) ack returns zero data.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ret
            logic sel_this;
            assign sel_this   = granted && (grant_reg == 2'(gi));
            assign m_ack[gi]  = sel_this && (i_s_ack || timeout_hit);
            assign m_rdt[gi]  = (sel_this && !timeout_hit) ? i_s_rdt : '0;
        end
    endgenerate

    assign o_m0_ack = m_ack[0];
    assign o_m1_ack = m_ack[1];
    assign o_m2_ack = m_ack[2];
    assign o_m0_rdt = m_rdt[0];
    assign o_m1_rdt = m_rdt[1];
    assign o_m2_rdt = m_rdt[2];

    // Round-robin pick: first requester in order last+1, last+2, last (mod 3).
    logic       rr_found;
    logic [1:0] rr_winner;
    always_comb begin
        int idx;
        rr_found  = 1'b0;
        rr_winner = 2'd0;
        idx       = 0;
        for (int k = 1; k <= 3; k++) begin
            idx = (int'(last_reg) + k) % 3;
            if (!rr_found && m_cyc[idx]) begin
                rr_found  = 1'b1;
                rr_winner = 2'(idx);
            end
        end
    end

    // Next-state logic for the arbitration FSM and its bookkeeping.
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_next       = last_reg;
        cnt_next        = cnt_reg;
        err_master_next = err_master_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (rr_found) begin
                    grant_next = rr_winner;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (i_s_ack || timeout_hit) begin
                    last_next  = grant_reg;
                    cnt_next   = '0;
                    state_next = RELEASE;
                    if (timeout_hit) begin
                        err_master_next = grant_reg;
                    end
                end else begin
                    cnt_next = cnt_reg + TW'(1);
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; last-served=2 makes m0 first.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_reg      <= IDLE;
            grant_reg      <= 2'd0;
            last_reg       <= 2'd2;
            cnt_reg        <= '0;
            err_master_reg <= 2'd0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_reg       <= last_next;
            cnt_reg        <= cnt_next;
            err_master_reg <= err_master_next;
        end
    end

endmodule

// File: tb/tb_servant_wb_arbiter.sv
// Directed bench for servant_wb_arbiter with TIMEOUT=4. Inputs change 1ns
// after each rising edge; outputs are checked 1ns later, mid-cycle.
module tb_servant_wb_arbiter;

    logic        wb_clk;
    logic        wb_rst;
    logic [31:0] i_m0_adr, i_m1_adr, i_m2_adr;
    logic [31:0] i_m0_dat, i_m1_dat, i_m2_dat;
    logic [3:0]  i_m0_sel, i_m1_sel, i_m2_sel;
    logic        i_m0_we, i_m1_we, i_m2_we;
    logic        i_m0_cyc, i_m1_cyc, i_m2_cyc;
    logic [31:0] o_m0_rdt, o_m1_rdt, o_m2_rdt;
    logic        o_m0_ack, o_m1_ack, o_m2_ack;
    logic [31:0] o_s_adr, o_s_dat;
    logic [3:0]  o_s_sel;
    logic        o_s_we, o_s_cyc;
    logic [31:0] i_s_rdt;
    logic        i_s_ack;
    logic        o_err;
    logic [1:0]  o_err_master;

    // Slave model: either a manual ack, or a zero-wait slave acking any cycle.
    logic manual_ack;
    logic auto_ack;
    assign i_s_ack = manual_ack | (auto_ack & o_s_cyc);

    int checks   = 0;
    int failures = 0;

    servant_wb_arbiter #(.TIMEOUT(4), .TW(8)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .i_m0_adr(i_m0_adr), .i_m0_dat(i_m0_dat), .i_m0_sel(i_m0_sel),
        .i_m0_we(i_m0_we), .i_m0_cyc(i_m0_cyc), .o_m0_rdt(o_m0_rdt), .o_m0_ack(o_m0_ack),
        .i_m1_adr(i_m1_adr), .i_m1_dat(i_m1_dat), .i_m1_sel(i_m1_sel),
        .i_m1_we(i_m1_we), .i_m1_cyc(i_m1_cyc), .o_m1_rdt(o_m1_rdt), .o_m1_ack(o_m1_ack),
        .i_m2_adr(i_m2_adr), .i_m2_dat(i_m2_dat), .i_m2_sel(i_m2_sel),
        .i_m2_we(i_m2_we), .i_m2_cyc(i_m2_cyc), .o_m2_rdt(o_m2_rdt), .o_m2_ack(o_m2_ack),
        .o_s_adr(o_s_adr), .o_s_dat(o_s_dat), .o_s_sel(o_s_sel), .o_s_we(o_s_we),
        .o_s_cyc(o_s_cyc), .i_s_rdt(i_s_rdt), .i_s_ack(i_s_ack),
        .o_err(o_err), .o_err_master(o_err_master)
    );

    initial begin
        wb_clk = 1'b0;
        forever #5 wb_clk = ~wb_clk;
    end

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    logic [31:0] rr_adr [3];
    logic [1:0]  rr_order [4];
    logic [2:0]  acks;

    initial begin
        wb_rst = 1'b1;
        i_m0_adr = '0; i_m1_adr = '0; i_m2_adr = '0;
        i_m0_dat = '0; i_m1_dat = '0; i_m2_dat = '0;
        i_m0_sel = '0; i_m1_sel = '0; i_m2_sel = '0;
        i_m0_we = 1'b0; i_m1_we = 1'b0; i_m2_we = 1'b0;
        i_m0_cyc = 1'b0; i_m1_cyc = 1'b0; i_m2_cyc = 1'b0;
        i_s_rdt = '0; manual_ack = 1'b0; auto_ack = 1'b0;

        // Reset state
        tick(); tick();
        #1;
        chk("rst_s_cyc", 32'(o_s_cyc), 0);
        chk("rst_acks", 32'({o_m2_ack, o_m1_ack, o_m0_ack}), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_err_master", 32'(o_err_master), 0);

        // Single requester: m1 read, slave acks one cycle after cyc rises
        wb_rst = 1'b0;
        i_m1_cyc = 1'b1; i_m1_adr = 32'h100;
        #1;
        chk("single_idle_cyc", 32'(o_s_cyc), 0);
        tick();
        chk("single_grant_cyc", 32'(o_s_cyc), 1);
        chk("single_adr", o_s_adr, 32'h100);
        chk("single_no_ack_yet", 32'(o_m1_ack), 0);
        tick();
        manual_ack = 1'b1; i_s_rdt = 32'hDEADBEEF;
        #1;
        chk("single_m1_ack", 32'(o_m1_ack), 1);
        chk("single_m1_rdt", o_m1_rdt, 32'hDEADBEEF);
        chk("single_other_acks", 32'({o_m2_ack, o_m0_ack}), 0);
        chk("single_m2_rdt", o_m2_rdt, 0);
        tick();
        manual_ack = 1'b0; i_m1_cyc = 1'b0;
        #1;
        chk("single_release_cyc", 32'(o_s_cyc), 0);
        chk("single_release_ack", 32'(o_m1_ack), 0);
        tick();

        // Round-robin from reset with all masters requesting, zero-wait slave
        wb_rst = 1'b1;
        tick();
        wb_rst = 1'b0;
        rr_adr[0] = 32'hA0; rr_adr[1] = 32'hA1; rr_adr[2] = 32'hA2;
        rr_order[0] = 2'd0; rr_order[1] = 2'd1; rr_order[2] = 2'd2; rr_order[3] = 2'd0;
        i_m0_adr = rr_adr[0]; i_m1_adr = rr_adr[1]; i_m2_adr = rr_adr[2];
        i_m0_cyc = 1'b1; i_m1_cyc = 1'b1; i_m2_cyc = 1'b1;
        auto_ack = 1'b1; i_s_rdt = 32'h0BADF00D;
        #1;
        chk("rr_idle_cyc", 32'(o_s_cyc), 0);
        for (int n = 0; n < 4; n++) begin
            tick();
            acks = 3'b000;
            acks[rr_order[n]] = 1'b1;
            chk($sformatf("rr%0d_grant_cyc", n), 32'(o_s_cyc), 1);
            chk($sformatf("rr%0d_adr", n), o_s_adr, rr_adr[rr_order[n]]);
            chk($sformatf("rr%0d_acks", n), 32'({o_m2_ack, o_m1_ack, o_m0_ack}), 32'(acks));
            tick();
            chk($sformatf("rr%0d_release_cyc", n), 32'(o_s_cyc), 0);
            chk($sformatf("rr%0d_release_acks", n), 32'({o_m2_ack, o_m1_ack, o_m0_ack}), 0);
            tick();
            chk($sformatf("rr%0d_idle_cyc", n), 32'(o_s_cyc), 0);
            if (n == 3) begin
                i_m0_cyc = 1'b0; i_m1_cyc = 1'b0; i_m2_cyc = 1'b0;
                auto_ack = 1'b0;
            end
        end
        tick();

        // Write passthrough from m2
        i_m2_adr = 32'h2000; i_m2_dat = 32'h12345678; i_m2_sel = 4'h3;
        i_m2_we = 1'b1; i_m2_cyc = 1'b1;
        tick();
        chk("wr_cyc", 32'(o_s_cyc), 1);
        chk("wr_adr", o_s_adr, 32'h2000);
        chk("wr_dat", o_s_dat, 32'h12345678);
        chk("wr_sel", 32'(o_s_sel), 32'h3);
        chk("wr_we", 32'(o_s_we), 1);
        chk("wr_no_ack_yet", 32'({o_m2_ack, o_m1_ack, o_m0_ack}), 0);
        manual_ack = 1'b1;
        #1;
        chk("wr_m2_ack", 32'(o_m2_ack), 1);
        chk("wr_other_acks", 32'({o_m1_ack, o_m0_ack}), 0);
        tick();
        manual_ack = 1'b0; i_m2_cyc = 1'b0; i_m2_we = 1'b0;
        #1;
        chk("wr_release_cyc", 32'(o_s_cyc), 0);
        tick();

        // Timeout on m0 (m1 also waiting), then m1 hits the ack/timeout tie
        i_m0_adr = 32'h40; i_m0_cyc = 1'b1;
        i_m1_adr = 32'h111; i_m1_cyc = 1'b1;
        i_s_rdt = 32'hCAFEF00D;
        tick();
        chk("to_grant_adr", o_s_adr, 32'h40);
        chk("to_c1_ack", 32'(o_m0_ack), 0);
        tick(); tick();
        chk("to_c3_ack", 32'(o_m0_ack), 0);
        chk("to_c3_err", 32'(o_err), 0);
        tick();
        chk("to_c4_ack", 32'(o_m0_ack), 1);
        chk("to_c4_err", 32'(o_err), 1);
        chk("to_c4_rdt", o_m0_rdt, 0);
        chk("to_c4_err_master", 32'(o_err_master), 0);
        chk("to_c4_cyc", 32'(o_s_cyc), 1);
        tick();
        i_m0_cyc = 1'b0;
        #1;
        chk("to_release_cyc", 32'(o_s_cyc), 0);
        chk("to_release_err", 32'(o_err), 0);
        chk("to_release_ack", 32'(o_m0_ack), 0);
        tick();
        chk("to_idle_cyc", 32'(o_s_cyc), 0);
        tick();
        chk("tie_grant_cyc", 32'(o_s_cyc), 1);
        chk("tie_grant_adr", o_s_adr, 32'h111);
        tick(); tick(); tick();
        manual_ack = 1'b1; i_s_rdt = 32'h55AA55AA;
        #1;
        chk("tie_m1_ack", 32'(o_m1_ack), 1);
        chk("tie_m1_rdt", o_m1_rdt, 32'h55AA55AA);
        chk("tie_err", 32'(o_err), 0);
        tick();
        manual_ack = 1'b0; i_m1_cyc = 1'b0;
        #1;
        chk("tie_release_cyc", 32'(o_s_cyc), 0);
        chk("tie_release_err", 32'(o_err), 0);
        tick();

        // Timeout on m2 to see o_err_master latch a non-zero index
        i_m2_cyc = 1'b1; i_s_rdt = 32'h0;
        tick(); tick(); tick(); tick();
        chk("to2_err", 32'(o_err), 1);
        chk("to2_m2_ack", 32'(o_m2_ack), 1);
        tick();
        i_m2_cyc = 1'b0;
        #1;
        chk("to2_err_master_held", 32'(o_err_master), 2);
        tick();

        // Reset mid-grant on m1, then all request: m0 first
        i_m1_cyc = 1'b1;
        tick();
        chk("rstg_grant_cyc", 32'(o_s_cyc), 1);
        chk("rstg_grant_adr", o_s_adr, 32'h111);
        wb_rst = 1'b1;
        tick();
        manual_ack = 1'b1; i_s_rdt = 32'h77777777;
        i_m0_cyc = 1'b1; i_m2_cyc = 1'b1;
        #1;
        chk("rstg_after_cyc", 32'(o_s_cyc), 0);
        chk("rstg_after_ack", 32'(o_m1_ack), 0);
        tick();
        wb_rst = 1'b0;
        #1;
        chk("rstg_idle_cyc", 32'(o_s_cyc), 0);
        tick();
        chk("rstg_first_cyc", 32'(o_s_cyc), 1);
        chk("rstg_first_adr", o_s_adr, 32'h40);
        chk("rstg_first_acks", 32'({o_m2_ack, o_m1_ack, o_m0_ack}), 32'h1);
        manual_ack = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
